mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/liang_pkg.sv | 28 ++
 rtl/arb_rr2.sv | 24 ++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/liang_pkg.sv
// liang_pkg: shared types for the memory arbiter.
//   XLEN        - data/address width
//   arb_state_e - arbiter FSM states
//   arb_owner_e - which requester owns the outstanding transaction
//   mem_req_t   - latched memory request fields
package liang_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP
    } arb_state_e;

    typedef enum logic {
        OWNER_IFU,
        OWNER_LSU
    } arb_owner_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            we;
        logic [XLEN-1:0] wdata;
        logic [3:0]      wmask;
    } mem_req_t;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way round-robin grant.
//   req        - in  [1:0] request vector, bit 0 = IFU, bit 1 = LSU
//   last_grant - in        owner granted most recently
//   grant      - out [1:0] one-hot grant (all zero when nobody requests)
module arb_rr2
    import liang_pkg::*;
(
    input  logic [1:0] req,
    input  arb_owner_e last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contention: favour whoever was not served last.
            2'b11:   grant = (last_grant == OWNER_IFU) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (IFU, read-only)
// and load/store (LSU), one transaction outstanding at a time.
//   clk_i, rst_ni                  - clock, async active-low reset
//   ifu_req_* / ifu_addr_i         - IFU request handshake and address
//   ifu_rsp_valid_o / ifu_rdata_o  - IFU response (one-cycle pulse, data held)
//   lsu_req_* / lsu_addr_i, ...    - LSU request handshake, address, write fields
//   lsu_rsp_valid_o / lsu_rdata_o  - LSU response (one-cycle pulse, data held)
//   mem_req_* / mem_*_o            - request to memory (fields zero when not valid)
//   mem_rsp_valid_i / mem_rdata_i  - memory response (read data or write ack)
module mem_arbiter
    import liang_pkg::*;
#(
    parameter int unsigned XLEN = liang_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            ifu_req_valid_i,
    output logic            ifu_req_ready_o,
    input  logic [XLEN-1:0] ifu_addr_i,
    output logic            ifu_rsp_valid_o,
    output logic [XLEN-1:0] ifu_rdata_o,

    input  logic            lsu_req_valid_i,
    output logic            lsu_req_ready_o,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic            lsu_we_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    input  logic [3:0]      lsu_wmask_i,
    output logic            lsu_rsp_valid_o,
    output logic [XLEN-1:0] lsu_rdata_o,

    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_wmask_o,
    input  logic            mem_rsp_valid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    arb_state_e      state_q, state_d;
    arb_owner_e      last_grant_q, last_grant_d;
    arb_owner_e      owner_q, owner_d;
    mem_req_t        req_q, req_d;
    logic            ifu_rsp_valid_q, ifu_rsp_valid_d;
    logic            lsu_rsp_valid_q, lsu_rsp_valid_d;
    logic [XLEN-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [XLEN-1:0] lsu_rdata_q, lsu_rdata_d;
    logic [1:0]      grant;

    arb_rr2 u_arb_rr2 (
        .req        ({lsu_req_valid_i, ifu_req_valid_i}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        owner_d         = owner_q;
        req_d           = req_q;
        ifu_rsp_valid_d = 1'b0;
        lsu_rsp_valid_d = 1'b0;
        ifu_rdata_d     = ifu_rdata_q;
        lsu_rdata_d     = lsu_rdata_q;
        ifu_req_ready_o = 1'b0;
        lsu_req_ready_o = 1'b0;
        mem_req_valid_o = 1'b0;

        case (state_q)
            IDLE: begin
                // Ready only goes to the granted side, so valid&ready == grant.
                ifu_req_ready_o = grant[0];
                lsu_req_ready_o = grant[1];
                if (grant[0]) begin
                    req_d        = '{addr: ifu_addr_i, we: 1'b0, wdata: '0, wmask: 4'b0000};
                    owner_d      = OWNER_IFU;
                    last_grant_d = OWNER_IFU;
                    state_d      = REQ;
                end else if (grant[1]) begin
                    req_d        = '{addr: lsu_addr_i, we: lsu_we_i, wdata: lsu_wdata_i,
                                     wmask: lsu_wmask_i};
                    owner_d      = OWNER_LSU;
                    last_grant_d = OWNER_LSU;
                    state_d      = REQ;
                end
            end
            REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid_i) begin
                    if (owner_q == OWNER_LSU) begin
                        lsu_rsp_valid_d = 1'b1;
                        lsu_rdata_d     = req_q.we ? '0 : mem_rdata_i;
                    end else begin
                        ifu_rsp_valid_d = 1'b1;
                        ifu_rdata_d     = mem_rdata_i;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields are forced to zero whenever no request is presented.
    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        mem_wmask_o = 4'b0000;
        if (mem_req_valid_o) begin
            mem_addr_o  = req_q.addr;
            mem_we_o    = req_q.we;
            mem_wdata_o = req_q.wdata;
            mem_wmask_o = req_q.wmask;
        end
    end

    assign ifu_rsp_valid_o = ifu_rsp_valid_q;
    assign lsu_rsp_valid_o = lsu_rsp_valid_q;
    assign ifu_rdata_o     = ifu_rdata_q;
    assign lsu_rdata_o     = lsu_rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            last_grant_q    <= OWNER_IFU;
            owner_q         <= OWNER_IFU;
            req_q           <= '0;
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            ifu_rdata_q     <= '0;
            lsu_rdata_q     <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            owner_q         <= owner_d;
            req_q           <= req_d;
            ifu_rsp_valid_q <= ifu_rsp_valid_d;
            lsu_rsp_valid_q <= lsu_rsp_valid_d;
            ifu_rdata_q     <= ifu_rdata_d;
            lsu_rdata_q     <= lsu_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

    localparam int unsigned W = 32;

    logic         clk_i;
    logic         rst_ni;
    logic         ifu_req_valid_i, ifu_req_ready_o;
    logic [W-1:0] ifu_addr_i;
    logic         ifu_rsp_valid_o;
    logic [W-1:0] ifu_rdata_o;
    logic         lsu_req_valid_i, lsu_req_ready_o;
    logic [W-1:0] lsu_addr_i;
    logic         lsu_we_i;
    logic [W-1:0] lsu_wdata_i;
    logic [3:0]   lsu_wmask_i;
    logic         lsu_rsp_valid_o;
    logic [W-1:0] lsu_rdata_o;
    logic         mem_req_valid_o, mem_req_ready_i;
    logic [W-1:0] mem_addr_o;
    logic         mem_we_o;
    logic [W-1:0] mem_wdata_o;
    logic [3:0]   mem_wmask_o;
    logic         mem_rsp_valid_i;
    logic [W-1:0] mem_rdata_i;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(.XLEN(W)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .ifu_req_valid_i (ifu_req_valid_i),
        .ifu_req_ready_o (ifu_req_ready_o),
        .ifu_addr_i      (ifu_addr_i),
        .ifu_rsp_valid_o (ifu_rsp_valid_o),
        .ifu_rdata_o     (ifu_rdata_o),
        .lsu_req_valid_i (lsu_req_valid_i),
        .lsu_req_ready_o (lsu_req_ready_o),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_wdata_i     (lsu_wdata_i),
        .lsu_wmask_i     (lsu_wmask_i),
        .lsu_rsp_valid_o (lsu_rsp_valid_o),
        .lsu_rdata_o     (lsu_rdata_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_addr_o      (mem_addr_o),
        .mem_we_o        (mem_we_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_wmask_o     (mem_wmask_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rdata_i     (mem_rdata_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        ifu_req_valid_i = 1'b0;
        ifu_addr_i      = '0;
        lsu_req_valid_i = 1'b0;
        lsu_addr_i      = '0;
        lsu_we_i        = 1'b0;
        lsu_wdata_i     = '0;
        lsu_wmask_i     = 4'b0000;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i     = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ifu_rdy"},  ifu_req_ready_o, 0);
        check({tag, "_lsu_rdy"},  lsu_req_ready_o, 0);
        check({tag, "_mem_vld"},  mem_req_valid_o, 0);
        check({tag, "_ifu_rsp"},  ifu_rsp_valid_o, 0);
        check({tag, "_lsu_rsp"},  lsu_rsp_valid_o, 0);
        check({tag, "_ifu_rd"},   ifu_rdata_o, 0);
        check({tag, "_lsu_rd"},   lsu_rdata_o, 0);
        check({tag, "_mem_addr"}, mem_addr_o, 0);
        check({tag, "_mem_we"},   mem_we_o, 0);
        check({tag, "_mem_wd"},   mem_wdata_o, 0);
        check({tag, "_mem_wm"},   {28'b0, mem_wmask_o}, 0);
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        check_all_zero(tag);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b1;
        idle_inputs();

        // IFU read with immediate memory ready, data one cycle later.
        do_reset("rst0");
        tick();
        ifu_req_valid_i = 1'b1;
        ifu_addr_i      = 32'h8000_0000;
        mem_req_ready_i = 1'b1;
        settle();
        check("t1_ifu_rdy", ifu_req_ready_o, 1);
        check("t1_lsu_rdy", lsu_req_ready_o, 0);
        check("t1_idle_vld", mem_req_valid_o, 0);
        check("t1_idle_addr", mem_addr_o, 0);
        tick();
        ifu_req_valid_i = 1'b0;
        ifu_addr_i      = '0;
        settle();
        check("t1_req_vld", mem_req_valid_o, 1);
        check("t1_req_addr", mem_addr_o, 32'h8000_0000);
        check("t1_req_we", mem_we_o, 0);
        check("t1_req_wm", {28'b0, mem_wmask_o}, 0);
        check("t1_req_rdy", ifu_req_ready_o, 0);
        tick();
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 32'hDEAD_BEEF;
        settle();
        check("t1_wait_vld", mem_req_valid_o, 0);
        check("t1_wait_rsp", ifu_rsp_valid_o, 0);
        tick();
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i     = '0;
        settle();
        check("t1_rsp_vld", ifu_rsp_valid_o, 1);
        check("t1_rsp_data", ifu_rdata_o, 32'hDEAD_BEEF);
        check("t1_lsu_rsp", lsu_rsp_valid_o, 0);
        tick();
        settle();
        check("t1_pulse_end", ifu_rsp_valid_o, 0);
        check("t1_data_held", ifu_rdata_o, 32'hDEAD_BEEF);

        // Contention from reset: LSU, IFU, LSU, IFU.
        do_reset("rst1");
        tick();
        ifu_req_valid_i = 1'b1;
        ifu_addr_i      = 32'h0000_0100;
        lsu_req_valid_i = 1'b1;
        lsu_addr_i      = 32'h0000_0200;
        mem_req_ready_i = 1'b1;
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 32'h5A5A_0000;
        for (int i = 0; i < 4; i++) begin
            logic exp_lsu;
            exp_lsu = (i % 2 == 0);
            settle();
            check($sformatf("t2_lsu_rdy%0d", i), lsu_req_ready_o, exp_lsu);
            check($sformatf("t2_ifu_rdy%0d", i), ifu_req_ready_o, !exp_lsu);
            if (i > 0) begin
                check($sformatf("t2_lsu_rsp%0d", i), lsu_rsp_valid_o, !exp_lsu);
                check($sformatf("t2_ifu_rsp%0d", i), ifu_rsp_valid_o, exp_lsu);
            end
            tick();
            settle();
            check($sformatf("t2_addr%0d", i), mem_addr_o,
                  exp_lsu ? 32'h0000_0200 : 32'h0000_0100);
            tick();
            settle();
            check($sformatf("t2_wait%0d", i), mem_req_valid_o, 0);
            tick();
        end
        settle();
        check("t2_last_ifu_rsp", ifu_rsp_valid_o, 1);
        check("t2_last_ifu_rd", ifu_rdata_o, 32'h5A5A_0000);

        // LSU write with memory back-pressure for three cycles.
        do_reset("rst2");
        tick();
        lsu_req_valid_i = 1'b1;
        lsu_we_i        = 1'b1;
        lsu_addr_i      = 32'h8000_0010;
        lsu_wdata_i     = 32'h1234_5678;
        lsu_wmask_i     = 4'b0011;
        settle();
        check("t3_lsu_rdy", lsu_req_ready_o, 1);
        tick();
        lsu_req_valid_i = 1'b0;
        lsu_we_i        = 1'b0;
        lsu_addr_i      = 32'hFFFF_FFFF;
        lsu_wdata_i     = 32'hFFFF_FFFF;
        lsu_wmask_i     = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            mem_req_ready_i = (k == 3);
            settle();
            check($sformatf("t3_vld%0d", k), mem_req_valid_o, 1);
            check($sformatf("t3_addr%0d", k), mem_addr_o, 32'h8000_0010);
            check($sformatf("t3_we%0d", k), mem_we_o, 1);
            check($sformatf("t3_wd%0d", k), mem_wdata_o, 32'h1234_5678);
            check($sformatf("t3_wm%0d", k), {28'b0, mem_wmask_o}, 32'h3);
            tick();
        end
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 32'hCAFE_F00D;
        settle();
        check("t3_wait_vld", mem_req_valid_o, 0);
        check("t3_wait_addr", mem_addr_o, 0);
        check("t3_wait_we", mem_we_o, 0);
        check("t3_wait_wd", mem_wdata_o, 0);
        tick();
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i     = '0;
        settle();
        check("t3_ack", lsu_rsp_valid_o, 1);
        check("t3_ack_data", lsu_rdata_o, 0);
        check("t3_ifu_rsp", ifu_rsp_valid_o, 0);
        tick();
        settle();
        check("t3_ack_end", lsu_rsp_valid_o, 0);

        // Stray responses in IDLE and in the ready cycle are ignored.
        tick();
        ifu_req_valid_i = 1'b1;
        ifu_addr_i      = 32'h0000_0040;
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 32'hBAD0_0001;
        settle();
        check("t4_ifu_rdy", ifu_req_ready_o, 1);
        tick();
        ifu_req_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        mem_rdata_i     = 32'hBAD0_0002;
        settle();
        check("t4_req_vld", mem_req_valid_o, 1);
        check("t4_req_rsp", ifu_rsp_valid_o, 0);
        tick();
        mem_req_ready_i = 1'b0;
        mem_rdata_i     = 32'h600D_0003;
        settle();
        check("t4_wait_rsp", ifu_rsp_valid_o, 0);
        check("t4_wait_lsu", lsu_rsp_valid_o, 0);
        tick();
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i     = '0;
        settle();
        check("t4_rsp", ifu_rsp_valid_o, 1);
        check("t4_rsp_data", ifu_rdata_o, 32'h600D_0003);
        check("t4_lsu_rsp", lsu_rsp_valid_o, 0);

        // Reset during WAIT_RSP, then a stray response after release.
        tick();
        ifu_req_valid_i = 1'b1;
        ifu_addr_i      = 32'h0000_0300;
        mem_req_ready_i = 1'b1;
        settle();
        tick();
        ifu_req_valid_i = 1'b0;
        ifu_addr_i      = '0;
        settle();
        check("t5_req_vld", mem_req_valid_o, 1);
        tick();
        mem_req_ready_i = 1'b0;
        rst_ni          = 1'b0;
        #1;
        check_all_zero("t5_inrst");
        tick();
        tick();
        rst_ni = 1'b1;
        settle();
        check_all_zero("t5_rel");
        tick();
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 32'hBADB_AD00;
        settle();
        check_all_zero("t5_stray");
        tick();
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i     = '0;
        settle();
        check_all_zero("t5_after");
        tick();
        ifu_req_valid_i = 1'b1;
        ifu_addr_i      = 32'h0000_0400;
        settle();
        check("t5_idle_rdy", ifu_req_ready_o, 1);
        tick();
        ifu_req_valid_i = 1'b0;
        settle();
        check("t5_new_vld", mem_req_valid_o, 1);
        check("t5_new_addr", mem_addr_o, 32'h0000_0400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
